// File: rtl/frame_scheduler.sv
// Sequences the core over NUM_FRAMES consecutive frames, then pulses debug_start; all outputs registered (1-cycle latency).
// Waits on core handshakes (start_clr_sys, intr_sys) with a per-state timeout; abort returns to IDLE.
module frame_scheduler #(
  parameter int ADDR_W     = 19,
  parameter int FRAME_STEP = 576,
  parameter int NUM_FRAMES = 16,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 1048576,
  parameter int TO_W       = 21
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              go,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              start_clr_sys,
  input  logic              intr_sys,
  output logic              start_sys,
  output logic              intr_clr_sys,
  output logic [ADDR_W-1:0] start_music_addr,
  output logic              debug_start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_CLR, S_NEXT, S_DUMP, S_DONE, S_ERR
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_go_q, r_go_armed;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_start, r_clr, r_dbg, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_go_rise, w_waiting, w_expired;
  logic              w_start_nxt, w_clr_nxt, w_dbg_nxt, w_done_nxt, w_err_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // A go level still high when reset releases must fall once before it can count as an edge.
  assign w_go_rise = go & ~r_go_q & r_go_armed;
  assign w_waiting = (r_state == S_ARM) || (r_state == S_RUN) || (r_state == S_CLR);
  assign w_expired = w_waiting && (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = r_start;
    w_clr_nxt   = r_clr;
    w_dbg_nxt   = r_dbg;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_start_nxt = 1'b0;
      w_clr_nxt   = 1'b0;
      w_dbg_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end else if (w_expired) begin
      w_state_nxt = S_ERR;
      w_start_nxt = 1'b0;
      w_clr_nxt   = 1'b0;
      w_err_nxt   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_go_rise) begin
            w_state_nxt = S_ARM;
            w_addr_nxt  = base_addr;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_start_nxt = 1'b1;
          end
        end
        S_ARM: begin
          if (start_clr_sys) begin
            w_state_nxt = S_RUN;
            w_start_nxt = 1'b0;
          end
        end
        S_RUN: begin
          if (intr_sys) begin
            w_state_nxt = S_CLR;
            w_clr_nxt   = 1'b1;
          end
        end
        S_CLR: begin
          if (!intr_sys) begin
            w_state_nxt = S_NEXT;
            w_clr_nxt   = 1'b0;
          end
        end
        S_NEXT: begin
          if (r_cnt == CNT_W'(NUM_FRAMES - 1)) begin
            w_state_nxt = S_DUMP;
            w_dbg_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_ARM;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_addr_nxt  = r_addr + ADDR_W'(FRAME_STEP);
            w_start_nxt = 1'b1;
          end
        end
        S_DUMP: begin
          w_state_nxt = S_DONE;
          w_dbg_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_go_q     <= 1'b0;
      r_go_armed <= 1'b0;
      r_to_cnt   <= '0;
      r_start    <= 1'b0;
      r_clr      <= 1'b0;
      r_dbg      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_go_q     <= go;
      r_go_armed <= r_go_armed | ~go;
      r_to_cnt   <= (w_waiting && (w_state_nxt == r_state)) ? r_to_cnt + TO_W'(1) : '0;
      r_start    <= w_start_nxt;
      r_clr      <= w_clr_nxt;
      r_dbg      <= w_dbg_nxt;
      r_busy     <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) || (w_state_nxt == S_ERR));
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign start_sys        = r_start;
  assign intr_clr_sys     = r_clr;
  assign debug_start      = r_dbg;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err_timeout      = r_err;
  assign start_music_addr = r_addr;
  assign frame_cnt        = r_cnt;

endmodule

// File: tb/tb_frame_scheduler.sv
// Randomized run-level checks of frame_scheduler against a transaction-level expectation model.
module tb_frame_scheduler;
  localparam int ADDR_W     = 19;
  localparam int FRAME_STEP = 576;
  localparam int NUM_FRAMES = 3;
  localparam int CNT_W      = 8;
  localparam int TIMEOUT    = 16;
  localparam int TO_W       = 5;

  logic              clk_in, rst_n, go, abort, start_clr_sys, intr_sys;
  logic [ADDR_W-1:0] base_addr;
  logic              start_sys, intr_clr_sys, debug_start, busy, done, err_timeout;
  logic [ADDR_W-1:0] start_music_addr;
  logic [CNT_W-1:0]  frame_cnt;

  frame_scheduler #(
    .ADDR_W(ADDR_W), .FRAME_STEP(FRAME_STEP), .NUM_FRAMES(NUM_FRAMES),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .go(go), .abort(abort), .base_addr(base_addr),
    .start_clr_sys(start_clr_sys), .intr_sys(intr_sys), .start_sys(start_sys),
    .intr_clr_sys(intr_clr_sys), .start_music_addr(start_music_addr),
    .debug_start(debug_start), .busy(busy), .done(done), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  // Expected address of frame k: plain modular arithmetic.
  function automatic logic [63:0] exp_addr(input int base, input int k);
    longint v;
    v = (longint'(base) + longint'(k) * FRAME_STEP) % (longint'(1) << ADDR_W);
    return 64'(v);
  endfunction

  // Core model: ack after ack_dly, interrupt after intr_dly, drop interrupt clr_dly after clear.
  bit core_en   = 1'b0;
  bit core_hang = 1'b0;
  int ack_dly   = 2;
  int intr_dly  = 10;
  int clr_dly   = 1;
  int c_phase, c_wait;

  initial begin
    start_clr_sys = 1'b0;
    intr_sys      = 1'b0;
    c_phase       = 0;
    c_wait        = 0;
    forever begin
      @(negedge clk_in);
      if (!core_en) begin
        c_phase = 0; start_clr_sys = 1'b0; intr_sys = 1'b0;
      end else begin
        case (c_phase)
          0: if (start_sys) begin
               if (ack_dly == 0) begin start_clr_sys = 1'b1; c_phase = 2; end
               else begin c_wait = ack_dly - 1; c_phase = 1; end
             end
          1: if (c_wait == 0) begin start_clr_sys = 1'b1; c_phase = 2; end
             else c_wait--;
          2: begin
               start_clr_sys = 1'b0;
               if (core_hang) c_phase = 5;
               else if (intr_dly == 0) begin intr_sys = 1'b1; c_phase = 4; end
               else begin c_wait = intr_dly - 1; c_phase = 3; end
             end
          3: if (c_wait == 0) begin intr_sys = 1'b1; c_phase = 4; end
             else c_wait--;
          4: if (intr_clr_sys) begin c_wait = clr_dly; c_phase = 6; end
          6: if (c_wait == 0) begin intr_sys = 1'b0; c_phase = 0; end
             else c_wait--;
          default: ;
        endcase
      end
    end
  end

  // Transaction monitor.
  logic [ADDR_W-1:0] q_addr[$];
  int                q_cnt[$];
  int                n_clr_pulses = 0;
  int                n_dbg_cycles = 0;
  logic              p_start = 1'b0;
  logic              p_clr   = 1'b0;

  initial begin
    forever begin
      @(negedge clk_in);
      #2;
      if (start_sys && !p_start) begin
        q_addr.push_back(start_music_addr);
        q_cnt.push_back(int'(frame_cnt));
      end
      if (intr_clr_sys && !p_clr) n_clr_pulses++;
      if (debug_start) n_dbg_cycles++;
      p_start = start_sys;
      p_clr   = intr_clr_sys;
    end
  end

  int s_starts, s_clr, s_dbg;

  task automatic launch(input int base);
    base_addr = ADDR_W'(base);
    go = 1'b0;
    tick();
    s_starts = q_addr.size();
    s_clr    = n_clr_pulses;
    s_dbg    = n_dbg_cycles;
    go = 1'b1;
  endtask

  task automatic finish_run(input int base, input bit wiggle);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
      if (wiggle && ($urandom_range(0, 3) == 0)) go = ~go;
    end
    check("run_done", 64'(ok), 64'd1);
    tick();
    check("n_start", 64'(q_addr.size() - s_starts), 64'(NUM_FRAMES));
    for (int k = 0; k < NUM_FRAMES; k++) begin
      if (s_starts + k < q_addr.size()) begin
        check("frame_addr", 64'(q_addr[s_starts + k]), exp_addr(base, k));
        check("frame_idx", 64'(q_cnt[s_starts + k]), 64'(k));
      end
    end
    check("n_clr", 64'(n_clr_pulses - s_clr), 64'(NUM_FRAMES));
    check("n_dbg", 64'(n_dbg_cycles - s_dbg), 64'd1);
    check("end_cnt", 64'(frame_cnt), 64'(NUM_FRAMES - 1));
    check("end_addr", 64'(start_music_addr), exp_addr(base, NUM_FRAMES - 1));
    check("end_done", 64'(done), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("end_err", 64'(err_timeout), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 64'(start_sys), 64'd0);
    check({tag, "_clr"}, 64'(intr_clr_sys), 64'd0);
    check({tag, "_addr"}, 64'(start_music_addr), 64'd0);
    check({tag, "_dbg"}, 64'(debug_start), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err_timeout), 64'd0);
    check({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, b;
    bit  seen, found;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; base_addr = '0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Basic run with latency checks.
    core_en = 1'b1; ack_dly = 2; intr_dly = 10; clr_dly = 1;
    launch(100);
    tick();
    check("lat_start", 64'(start_sys), 64'd1);
    check("lat_busy", 64'(busy), 64'd1);
    tick(); tick();
    check("lat_ack_seen", 64'(start_clr_sys), 64'd1);
    check("lat_start_held", 64'(start_sys), 64'd1);
    tick();
    check("lat_start_fall", 64'(start_sys), 64'd0);
    finish_run(100, 1'b0);

    // Address wrap.
    ack_dly = 1; intr_dly = 3;
    launch(524000);
    finish_run(524000, 1'b0);
    if (q_addr.size() > s_starts + 1)
      check("wrap_addr", 64'(q_addr[s_starts + 1]), 64'd288);

    // Randomized runs with go toggling while busy.
    for (int r = 0; r < 6; r++) begin
      ack_dly  = $urandom_range(0, 5);
      intr_dly = $urandom_range(0, 10);
      clr_dly  = $urandom_range(0, 4);
      b = int'($urandom_range(0, (1 << ADDR_W) - 1));
      launch(b);
      finish_run(b, 1'b1);
    end

    // Timeout: core never interrupts.
    core_hang = 1'b1; ack_dly = 1;
    launch(2000);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (start_sys) seen = 1'b1;
      else if (seen) break;
    end
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (err_timeout) begin lat = j; break; end
    end
    check("to_latency", 64'(lat), 64'(TIMEOUT));
    check("to_busy", 64'(busy), 64'd0);
    check("to_start", 64'(start_sys), 64'd0);
    check("to_clr", 64'(intr_clr_sys), 64'd0);
    core_en = 1'b0; tick();
    core_hang = 1'b0; core_en = 1'b1;
    launch(3000);
    tick();
    check("to_err_clr", 64'(err_timeout), 64'd0);
    check("to_restart_busy", 64'(busy), 64'd1);
    finish_run(3000, 1'b0);

    // Abort in CLR while the interrupt is still high.
    ack_dly = 1; intr_dly = 2; clr_dly = 8;
    launch(5000);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (intr_clr_sys) begin found = 1'b1; break; end
    end
    check("abort_reach_clr", 64'(found), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_clr", 64'(intr_clr_sys), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    check("abort_no_restart", 64'(busy), 64'd0);
    check("abort_n_start", 64'(q_addr.size() - s_starts), 64'd1);
    check("abort_no_dbg", 64'(n_dbg_cycles - s_dbg), 64'd0);
    core_en = 1'b0; tick(); core_en = 1'b1;

    // Reset mid-RUN on the second frame, go held high through release.
    ack_dly = 1; intr_dly = 6; clr_dly = 1;
    launch(7000);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if ((q_addr.size() - s_starts == 2) && !start_sys && !intr_clr_sys && busy) begin
        found = 1'b1; break;
      end
    end
    check("rst_reach_run2", 64'(found), 64'd1);
    check("rst_pre_cnt", 64'(frame_cnt), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    core_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    core_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy) seen = 1'b1;
    end
    check("rst_go_held", 64'(seen), 64'd0);
    launch(7000);
    finish_run(7000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences `process_top_with_quan` over a run of consecutive music frames. Per frame: programs `start_music_addr`, issues `start_sys`, waits for `intr_sys`, clears it with `intr_clr_sys`, and advances the address.
- After the last frame, fires a one-cycle `debug_start` so `debug_ram` dumps the result BRAM.
- Sits in the top level between the Start button and the processing core. Replaces the fixed `start_music_addr=0`, the tied-off `intr_clr_sys` and the direct `intr_sys`→`debug_start` connection.

Parameters:
- ADDR_W, 19, width of `start_music_addr` and `base_addr`.
- FRAME_STEP, 576, address increment per frame (samples per granule).
- NUM_FRAMES, 16, frames per run (≥1).
- CNT_W, 8, width of `frame_cnt`; must satisfy 2^CNT_W ≥ NUM_FRAMES.
- TIMEOUT, 1048576, maximum cycles spent in any wait state before error.
- TO_W, 21, timeout counter width.

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  run request, level input. The block detects a rising edge internally.
- abort  in  1  synchronous abort, level-sensitive.
- base_addr  in  ADDR_W  first frame address, sampled on accepted go edge.
- start_clr_sys  in  1  core acknowledge of `start_sys`.
- intr_sys  in  1  core frame-complete interrupt, level.
- start_sys  out  1  frame start request to core.
- intr_clr_sys  out  1  interrupt clear to core.
- start_music_addr  out  ADDR_W  current frame address.
- debug_start  out  1  one-cycle pulse to `debug_ram`.
- busy  out  1  high in any state except IDLE, DONE, ERR.
- done  out  1  run completed.
- err_timeout  out  1  run stopped on timeout.
- frame_cnt  out  CNT_W  index of current frame (0-based).

Behaviour:
- Reset, asynchronous: state=IDLE.
  - All outputs 0: `start_music_addr`=0, `frame_cnt`=0, `debug_start`=0.
  - Timeout counter 0, go-edge register 0.
- All outputs are registered. Decisions made in cycle n appear at n+1.
- Go edge: `go_rise = go & ~go_q`, with `go_q` registered every cycle. Go is accepted only in IDLE, DONE and ERR; it is ignored while busy.
- IDLE / DONE / ERR on `go_rise` → ARM:
  - `start_music_addr`←`base_addr`, `frame_cnt`←0.
  - `done`←0, `err_timeout`←0, `start_sys`←1.
- ARM: hold `start_sys`=1. When `start_clr_sys`=1 → RUN, `start_sys`←0.
- RUN: wait for `intr_sys`=1 → CLR, `intr_clr_sys`←1.
- CLR: hold `intr_clr_sys`=1 until `intr_sys` samples 0 → NEXT, `intr_clr_sys`←0.
- NEXT (one cycle):
  - If `frame_cnt`==NUM_FRAMES-1 → DUMP, `debug_start`←1.
  - Else: `frame_cnt`+1, `start_music_addr`←(`start_music_addr`+FRAME_STEP) mod 2^ADDR_W (wraps silently), → ARM with `start_sys`←1.
- DUMP: `debug_start` high exactly one cycle → DONE, `done`←1.
  - `done` stays high until the next accepted go.
  - `start_music_addr` and `frame_cnt` keep their last values.
- Timeout:
  - Counter clears on every state change.
  - Counter increments each cycle in ARM, RUN, CLR.
  - At count==TIMEOUT-1 → ERR: `start_sys`←0, `intr_clr_sys`←0, `err_timeout`←1.
- Abort:
  - `abort`=1 in any state except IDLE → IDLE next cycle.
  - `start_sys`, `intr_clr_sys`, `debug_start`, `done`, `err_timeout` are cleared. No `debug_start` is issued.
  - Abort in IDLE has no effect.
- Priority: abort > timeout > normal transition.
  - `abort` together with `go_rise` in DONE/ERR → IDLE.
  - `intr_sys` and timeout in the same RUN cycle → ERR.
- `intr_sys` already high on entry to RUN: CLR is entered on the first RUN cycle.
- `start_clr_sys` high outside ARM: ignored.
- Reset mid-run returns immediately to the reset values. The core is not cleared; its own reset handles that.
- Core contract: `start_sys` pulse width = cycles until ack; `intr_clr_sys` pulse width = cycles until `intr_sys` falls.

Test Plan:
- Basic run, NUM_FRAMES=3, base_addr=100; core model acks 2 cycles after `start_sys` and raises `intr_sys` 10 cycles later.
  - Required: `start_music_addr` 100 → 676 → 1252.
  - Required: exactly 3 `start_sys` and 3 `intr_clr_sys` pulses.
  - Required: one `debug_start` pulse, then `done`=1, `frame_cnt`=2.
- Latency: `go` rises at cycle 5 → `start_sys`=1 and `busy`=1 at cycle 6.
  - `start_clr_sys`=1 at cycle 8 → `start_sys`=0 at cycle 9.
- Address wrap, base_addr=524000, FRAME_STEP=576 → second frame addr = (524000+576) mod 2^19 = 288.
- Timeout, TIMEOUT=16, core never asserts `intr_sys` → `err_timeout`=1 exactly 16 cycles after RUN entry and `busy`=0.
  - A new `go` edge clears the error and restarts from base_addr.
- Abort in CLR with `intr_sys` still high → next cycle IDLE, `intr_clr_sys`=0, no `debug_start`.
  - Holding `go` high without a new edge does not restart.
- Reset asserted mid-RUN, frame 2 → all outputs 0 asynchronously, before the next clock edge.
  - `go` held high through reset release does not start a run until it falls and rises again.
